fp_mul_arbiter: RTL and testbench



---
 rtl/fp_mul_arbiter.sv | 141 ++++++++++++++
 tb/tb_fp_mul_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_arbiter.sv
// fp_mul_arbiter: round-robin sharing of one fixed-latency FP multiplier among N_REQ
// requesters; a tag pipeline steers each result into that requester's one-entry buffer.
module fp_mul_arbiter #(
   parameter int unsigned N_REQ   = 4,
   parameter int unsigned MUL_LAT = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [N_REQ-1:0]    req_valid,
   output logic [N_REQ-1:0]    req_ready,
   input  logic [32*N_REQ-1:0] req_x,
   input  logic [32*N_REQ-1:0] req_y,
   input  logic [3*N_REQ-1:0]  req_rmode,
   output logic                mul_valid,
   output logic [31:0]         fp_X,
   output logic [31:0]         fp_Y,
   output logic [2:0]          r_mode,
   input  logic [31:0]         fp_Z,
   input  logic                ovrf,
   input  logic                udrf,
   output logic [N_REQ-1:0]    rsp_valid,
   input  logic [N_REQ-1:0]    rsp_ready,
   output logic [32*N_REQ-1:0] rsp_z,
   output logic [N_REQ-1:0]    rsp_ovrf,
   output logic [N_REQ-1:0]    rsp_udrf
);

   localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   typedef logic [IW-1:0] idx_t;

   logic [31:0]        x_arr     [N_REQ];
   logic [31:0]        y_arr     [N_REQ];
   logic [2:0]         rm_arr    [N_REQ];

   logic [N_REQ-1:0]   busy_q, busy_d;
   logic [N_REQ-1:0]   rsp_valid_q, rsp_valid_d;
   logic [N_REQ-1:0]   elig, grant, cap_hot;
   idx_t               ptr_q, ptr_d, gnt_idx, cidx;
   logic               found, accept;
   int unsigned        cand;

   logic               mul_valid_q;
   logic [31:0]        fp_x_q, fp_y_q;
   logic [2:0]         rmode_q;

   logic [MUL_LAT-1:0] tag_v_q;
   idx_t               tag_idx_q [MUL_LAT];
   logic               tail_v;
   idx_t               tail_idx;

   logic [31:0]        rsp_z_q   [N_REQ];
   logic [N_REQ-1:0]   rsp_ovrf_q, rsp_udrf_q;

   for (genvar g = 0; g < N_REQ; g++) begin : g_lane
      assign x_arr[g]            = req_x[32*g +: 32];
      assign y_arr[g]            = req_y[32*g +: 32];
      assign rm_arr[g]           = req_rmode[3*g +: 3];
      assign rsp_z[32*g +: 32]   = rsp_z_q[g];
   end

   // Search ptr+1 .. ptr+N_REQ (wrapping); the first eligible index wins.
   always_comb begin
      elig    = req_valid & ~busy_q;
      grant   = '0;
      gnt_idx = ptr_q;
      found   = 1'b0;
      cand    = 0;
      cidx    = '0;
      for (int unsigned k = 1; k <= N_REQ; k++) begin
         cand = 32'(ptr_q) + k;
         if (cand >= N_REQ) cand = cand - N_REQ;
         cidx = idx_t'(cand);
         if (!found && elig[cidx]) begin
            found   = 1'b1;
            gnt_idx = cidx;
         end
      end
      if (found && rst_n) grant[gnt_idx] = 1'b1;
   end

   assign accept = |grant;

   always_comb begin
      tail_v   = tag_v_q[MUL_LAT-1];
      tail_idx = tag_idx_q[MUL_LAT-1];
      cap_hot  = '0;
      if (tail_v) cap_hot[tail_idx] = 1'b1;
      busy_d      = (busy_q | grant) & ~(rsp_valid_q & rsp_ready);
      rsp_valid_d = (rsp_valid_q & ~rsp_ready) | cap_hot;
      ptr_d       = accept ? gnt_idx : ptr_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q      <= '0;
         rsp_valid_q <= '0;
         ptr_q       <= idx_t'(N_REQ - 1);
         mul_valid_q <= 1'b0;
         fp_x_q      <= '0;
         fp_y_q      <= '0;
         rmode_q     <= '0;
         tag_v_q     <= '0;
         for (int unsigned i = 0; i < MUL_LAT; i++) tag_idx_q[i] <= '0;
         for (int unsigned i = 0; i < N_REQ; i++) rsp_z_q[i] <= '0;
         rsp_ovrf_q  <= '0;
         rsp_udrf_q  <= '0;
      end else begin
         busy_q      <= busy_d;
         rsp_valid_q <= rsp_valid_d;
         ptr_q       <= ptr_d;
         mul_valid_q <= accept;
         if (accept) begin
            fp_x_q  <= x_arr[gnt_idx];
            fp_y_q  <= y_arr[gnt_idx];
            rmode_q <= rm_arr[gnt_idx];
         end
         tag_v_q[0]   <= accept;
         tag_idx_q[0] <= gnt_idx;
         for (int unsigned i = 1; i < MUL_LAT; i++) begin
            tag_v_q[i]   <= tag_v_q[i-1];
            tag_idx_q[i] <= tag_idx_q[i-1];
         end
         // The tail tag lines up with fp_Z; busy guarantees the target buffer is empty.
         if (tail_v) begin
            rsp_z_q[tail_idx]    <= fp_Z;
            rsp_ovrf_q[tail_idx] <= ovrf;
            rsp_udrf_q[tail_idx] <= udrf;
         end
      end
   end

   assign req_ready = grant;
   assign mul_valid = mul_valid_q;
   assign fp_X      = fp_x_q;
   assign fp_Y      = fp_y_q;
   assign r_mode    = rmode_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_ovrf  = rsp_ovrf_q;
   assign rsp_udrf  = rsp_udrf_q;

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Directed bench for fp_mul_arbiter with a MUL_LAT-stage mock multiplier.
module tb_fp_mul_arbiter;

   localparam int N = 4;
   localparam int L = 3;

   logic            clk;
   logic            rst_n;
   logic [N-1:0]    req_valid, req_ready;
   logic [32*N-1:0] req_x, req_y;
   logic [3*N-1:0]  req_rmode;
   logic            mul_valid;
   logic [31:0]     fp_X, fp_Y, fp_Z;
   logic [2:0]      r_mode;
   logic            ovrf, udrf;
   logic [N-1:0]    rsp_valid, rsp_ready, rsp_ovrf, rsp_udrf;
   logic [32*N-1:0] rsp_z;

   int n_checks = 0;
   int n_err    = 0;

   fp_mul_arbiter #(.N_REQ(N), .MUL_LAT(L)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_x(req_x), .req_y(req_y), .req_rmode(req_rmode),
      .mul_valid(mul_valid), .fp_X(fp_X), .fp_Y(fp_Y), .r_mode(r_mode),
      .fp_Z(fp_Z), .ovrf(ovrf), .udrf(udrf),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_z(rsp_z), .rsp_ovrf(rsp_ovrf), .rsp_udrf(rsp_udrf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Mock multiplier: a few known products with flags, otherwise a bit-mixing function.
   function automatic logic [33:0] mock_mul(input logic [31:0] x, input logic [31:0] y,
                                            input logic [2:0] rm);
      if (x == 32'h3F800000 && y == 32'h40000000) return {32'h40000000, 2'b00};
      if (x == 32'h7F000000 && y == 32'h7F000000) return {32'h7F800000, 2'b10};
      if (x == 32'h00800000 && y == 32'h00800000) return {32'h00000000, 2'b01};
      return {x ^ {y[15:0], y[31:16]} ^ {29'd0, rm}, 2'b00};
   endfunction

   logic [31:0] s1x, s1y, s2x, s2y;
   logic [2:0]  s1r, s2r;
   always @(posedge clk) begin
      s1x <= fp_X; s1y <= fp_Y; s1r <= r_mode;
      s2x <= s1x;  s2y <= s1y;  s2r <= s1r;
   end
   assign {fp_Z, ovrf, udrf} = mock_mul(s2x, s2y, s2r);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input int i, input logic [31:0] x, input logic [31:0] y,
                         input logic [2:0] rm);
      req_x[32*i +: 32]   = x;
      req_y[32*i +: 32]   = y;
      req_rmode[3*i +: 3] = rm;
   endtask

   task automatic wait_grant(input int who, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 20 && !ok; c++) begin
         @(negedge clk);
         if (req_ready[who]) ok = 1'b1;
         tick();
      end
   endtask

   task automatic wait_rsp(input int who, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 20 && !ok; c++) begin
         if (rsp_valid[who]) ok = 1'b1;
         else tick();
      end
   endtask

   task automatic run_one(input int who, input logic [31:0] x, input logic [31:0] y,
                          input logic [2:0] rm, input string tag);
      bit          ok;
      logic [33:0] e;
      e = mock_mul(x, y, rm);
      rsp_ready[who] = 1'b0;
      set_op(who, x, y, rm);
      req_valid[who] = 1'b1;
      wait_grant(who, ok);
      check({tag, "_grant"}, 32'(ok), 32'd1);
      req_valid[who] = 1'b0;
      wait_rsp(who, ok);
      check({tag, "_rsp"}, 32'(ok), 32'd1);
      check({tag, "_z"}, rsp_z[32*who +: 32], e[33:2]);
      check({tag, "_ovrf"}, 32'(rsp_ovrf[who]), 32'(e[1]));
      check({tag, "_udrf"}, 32'(rsp_udrf[who]), 32'(e[0]));
      rsp_ready[who] = 1'b1;
      tick();
      rsp_ready[who] = 1'b0;
      check({tag, "_consumed"}, 32'(rsp_valid[who]), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   logic [31:0] xs [N];
   logic [31:0] ys [N];
   logic [3:0]  gseq [6];
   logic [33:0] e;
   int          ng, bad1, others, bad;
   bit          ok;

   initial begin
      rst_n = 1'b0; req_valid = '1; rsp_ready = '0;
      req_x = '0; req_y = '0; req_rmode = '0;
      #12;
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_mul_valid", 32'(mul_valid), 32'd0);
      check("rst_fp_X", fp_X, 32'd0);
      check("rst_fp_Y", fp_Y, 32'd0);
      check("rst_r_mode", 32'(r_mode), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_z_zero", 32'(|rsp_z), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1; req_valid = '0;

      // Single request from requester 2
      set_op(2, 32'h3F800000, 32'h40000000, 3'd0);
      req_valid = 4'b0100;
      @(negedge clk);
      check("t1_grant", 32'(req_ready), 32'h4);
      tick();
      req_valid = '0;
      check("t1_mul_valid", 32'(mul_valid), 32'd1);
      check("t1_fp_X", fp_X, 32'h3F800000);
      check("t1_fp_Y", fp_Y, 32'h40000000);
      check("t1_r_mode", 32'(r_mode), 32'd0);
      tick();
      check("t1_mul_valid_drop", 32'(mul_valid), 32'd0);
      check("t1_rsp_early2", 32'(rsp_valid), 32'd0);
      tick();
      check("t1_rsp_early3", 32'(rsp_valid), 32'd0);
      tick();
      check("t1_rsp_valid", 32'(rsp_valid), 32'h4);
      check("t1_rsp_z", rsp_z[95:64], 32'h40000000);
      check("t1_rsp_ovrf", 32'(rsp_ovrf[2]), 32'd0);
      check("t1_rsp_udrf", 32'(rsp_udrf[2]), 32'd0);
      req_valid = 4'b0100; rsp_ready = 4'b0100;
      @(negedge clk);
      check("t1_busy_blocks", 32'(req_ready), 32'd0);
      tick();
      rsp_ready = '0;
      check("t1_consumed", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      check("t1_regrant", 32'(req_ready), 32'h4);
      tick();
      req_valid = '0;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;

      // All four requesters valid after reset
      for (int k = 0; k < N; k++) begin
         xs[k] = 32'h12340000 + 32'(k);
         ys[k] = 32'hA5A50F0F ^ (32'(k) << 4);
         set_op(k, xs[k], ys[k], 3'(k));
      end
      req_valid = 4'b1111;
      for (int k = 0; k < N; k++) begin
         @(negedge clk);
         check($sformatf("t2_grant%0d", k), 32'(req_ready), 32'(1 << k));
         tick();
         req_valid[k] = 1'b0;
         check($sformatf("t2_mul_valid%0d", k), 32'(mul_valid), 32'd1);
         check($sformatf("t2_fp_X%0d", k), fp_X, xs[k]);
      end
      check("t2_rsp_order0", 32'(rsp_valid), 32'h1);
      tick();
      check("t2_rsp_order1", 32'(rsp_valid), 32'h3);
      tick();
      check("t2_rsp_order2", 32'(rsp_valid), 32'h7);
      tick();
      check("t2_rsp_order3", 32'(rsp_valid), 32'hF);
      for (int k = 0; k < N; k++) begin
         e = mock_mul(xs[k], ys[k], 3'(k));
         check($sformatf("t2_rsp_z%0d", k), rsp_z[32*k +: 32], e[33:2]);
      end
      rsp_ready = '1;
      tick();
      check("t2_all_consumed", 32'(rsp_valid), 32'd0);

      // Fairness between requesters 0 and 3
      set_op(0, 32'h01020304, 32'h05060708, 3'd1);
      set_op(3, 32'h0A0B0C0D, 32'h0E0F1011, 3'd2);
      req_valid = 4'b1001;
      ng = 0;
      for (int c = 0; c < 40 && ng < 6; c++) begin
         @(negedge clk);
         if (req_ready != '0) begin
            gseq[ng] = req_ready;
            ng++;
         end
         tick();
      end
      check("t3_grant_count", 32'(ng), 32'd6);
      for (int i = 0; i < 6; i++)
         check($sformatf("t3_seq%0d", i), 32'(gseq[i]), (i % 2 == 0) ? 32'h1 : 32'h8);
      req_valid = '0;
      repeat (8) tick();

      // Backpressure on requester 1
      rsp_ready = 4'b1101;
      set_op(1, 32'h3C003C00, 32'h40404040, 3'd3);
      req_valid = 4'b0010;
      wait_grant(1, ok);
      check("t4_grant1", 32'(ok), 32'd1);
      set_op(1, 32'h11112222, 32'h33334444, 3'd4);
      set_op(0, 32'h55556666, 32'h77778888, 3'd5);
      set_op(2, 32'h9999AAAA, 32'hBBBBCCCC, 3'd6);
      req_valid = 4'b0111;
      bad1 = 0; others = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (req_ready[1]) bad1++;
         if (req_ready[0] || req_ready[2]) others++;
         tick();
      end
      check("t4_req1_blocked", 32'(bad1), 32'd0);
      check("t4_others_issue", 32'(others >= 6), 32'd1);
      check("t4_rsp1_held", 32'(rsp_valid[1]), 32'd1);
      e = mock_mul(32'h3C003C00, 32'h40404040, 3'd3);
      check("t4_rsp1_z", rsp_z[63:32], e[33:2]);
      rsp_ready[1] = 1'b1;
      @(negedge clk);
      check("t4_no_same_cycle_regrant", 32'(req_ready[1]), 32'd0);
      tick();
      rsp_ready[1] = 1'b0;
      check("t4_rsp1_consumed", 32'(rsp_valid[1]), 32'd0);
      wait_grant(1, ok);
      check("t4_regrant1", 32'(ok), 32'd1);
      req_valid = '0;
      rsp_ready = '1;
      repeat (8) tick();
      rsp_ready = '0;

      // Flags pass through bit-exact
      run_one(0, 32'h7F000000, 32'h7F000000, 3'd0, "t5_ovf");
      run_one(0, 32'h00800000, 32'h00800000, 3'd1, "t5_udf");
      run_one(3, 32'hDEADBEEF, 32'h0BADF00D, 3'd7, "t5_plain");

      // Reset with three operations in flight
      set_op(0, 32'h10000001, 32'h20000002, 3'd1);
      set_op(1, 32'h30000003, 32'h40000004, 3'd2);
      set_op(2, 32'h50000005, 32'h60000006, 3'd3);
      req_valid = 4'b0111;
      tick(); tick(); tick();
      req_valid = '0;
      rst_n = 1'b0;
      #1;
      check("t6_mul_valid", 32'(mul_valid), 32'd0);
      check("t6_fp_X", fp_X, 32'd0);
      check("t6_fp_Y", fp_Y, 32'd0);
      check("t6_r_mode", 32'(r_mode), 32'd0);
      check("t6_rsp_valid", 32'(rsp_valid), 32'd0);
      check("t6_rsp_z_zero", 32'(|rsp_z), 32'd0);
      req_valid = 4'b1111;
      #1;
      check("t6_req_ready_in_reset", 32'(req_ready), 32'd0);
      req_valid = '0;
      tick();
      rst_n = 1'b1;
      bad = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (rsp_valid != '0 || mul_valid) bad++;
         tick();
      end
      check("t6_no_stale_rsp", 32'(bad), 32'd0);
      req_valid = 4'b1111;
      @(negedge clk);
      check("t6_first_grant", 32'(req_ready), 32'h1);
      tick();
      req_valid = '0;

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
